// File: rtl/skid.sv
// Registered valid/ready skid buffer: 1+FEED_STAGES cascaded two-entry stages.
// Every output (odat/ovld/irdy) comes straight from a flop, so no input-to-output path exists.

module skid_stage #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] idat,
  input  logic                  ivld,
  output logic                  irdy,
  output logic [DATA_WIDTH-1:0] odat,
  output logic                  ovld,
  input  logic                  ordy
);

  logic [DATA_WIDTH-1:0] a_dat_q, a_dat_d;
  logic                  a_vld_q, a_vld_d;
  logic [DATA_WIDTH-1:0] b_dat_q, b_dat_d;
  logic                  b_vld_q, b_vld_d;
  logic                  irdy_q, irdy_d;
  logic                  in_xfer;

  always_comb begin
    a_dat_d = a_dat_q;
    a_vld_d = a_vld_q;
    b_dat_d = b_dat_q;
    b_vld_d = b_vld_q;
    in_xfer = ivld && irdy_q;
    if (!a_vld_q || ordy) begin
      // A is free this edge: the oldest beat (B if present) moves into A
      if (b_vld_q) begin
        a_dat_d = b_dat_q;
        a_vld_d = 1'b1;
        b_vld_d = in_xfer;
        if (in_xfer) begin
          b_dat_d = idat;
        end
      end else begin
        a_vld_d = in_xfer;
        if (in_xfer) begin
          a_dat_d = idat;
        end
      end
    end else if (in_xfer) begin
      b_dat_d = idat;
      b_vld_d = 1'b1;
    end
    irdy_d = !b_vld_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_dat_q <= '0;
      a_vld_q <= 1'b0;
      b_dat_q <= '0;
      b_vld_q <= 1'b0;
      irdy_q  <= 1'b1;
    end else begin
      a_dat_q <= a_dat_d;
      a_vld_q <= a_vld_d;
      b_dat_q <= b_dat_d;
      b_vld_q <= b_vld_d;
      irdy_q  <= irdy_d;
    end
  end

  assign irdy = irdy_q;
  assign odat = a_dat_q;
  assign ovld = a_vld_q;

endmodule

module skid #(
  parameter int DATA_WIDTH  = 8,
  parameter int FEED_STAGES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] idat,
  input  logic                  ivld,
  output logic                  irdy,
  output logic [DATA_WIDTH-1:0] odat,
  output logic                  ovld,
  input  logic                  ordy
);

  localparam int NSTG = 1 + FEED_STAGES;

  // Link k carries the stream into stage k; link NSTG is the external output.
  logic [DATA_WIDTH-1:0] dat_c [0:NSTG];
  logic [NSTG:0]         vld_c;
  logic [NSTG:0]         rdy_c;

  assign dat_c[0]    = idat;
  assign vld_c[0]    = ivld;
  assign irdy        = rdy_c[0];
  assign odat        = dat_c[NSTG];
  assign ovld        = vld_c[NSTG];
  assign rdy_c[NSTG] = ordy;

  generate
    for (genvar gi = 0; gi < NSTG; gi++) begin : g_stage
      skid_stage #(
        .DATA_WIDTH(DATA_WIDTH)
      ) u_stage (
        .clk (clk),
        .rst (rst),
        .idat(dat_c[gi]),
        .ivld(vld_c[gi]),
        .irdy(rdy_c[gi]),
        .odat(dat_c[gi+1]),
        .ovld(vld_c[gi+1]),
        .ordy(rdy_c[gi+1])
      );
    end
  endgenerate

endmodule

// File: tb/tb_skid.sv
// Bench for skid: a single-stage and a three-stage instance checked against per-instance
// scoreboards, plus directed checks of reset, latency, backpressure and recovery.

module tb_skid;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] idat_a, odat_a, idat_b, odat_b;
  logic       ivld_a, irdy_a, ovld_a, ordy_a;
  logic       ivld_b, irdy_b, ovld_b, ordy_b;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  int         acc_a = 0, acc_b = 0;
  logic       stall_a = 1'b0, stall_b = 1'b0;
  logic [7:0] hold_a, hold_b;

  always #5 clk = ~clk;

  skid #(.DATA_WIDTH(8), .FEED_STAGES(0)) dut (
    .clk(clk), .rst(rst),
    .idat(idat_a), .ivld(ivld_a), .irdy(irdy_a),
    .odat(odat_a), .ovld(ovld_a), .ordy(ordy_a)
  );

  skid #(.DATA_WIDTH(8), .FEED_STAGES(2)) dut3 (
    .clk(clk), .rst(rst),
    .idat(idat_b), .ivld(ivld_b), .irdy(irdy_b),
    .odat(odat_b), .ovld(ovld_b), .ordy(ordy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes on the falling edge, let the rising edge happen, return 1 after it.
  task automatic cycle();
    logic [7:0] e;
    @(negedge clk);
    if (rst) begin
      q_a.delete(); q_b.delete();
      stall_a = 1'b0; stall_b = 1'b0;
    end else begin
      if (stall_a) begin
        chk("hold_vld_a", ovld_a, 1);
        chk("hold_dat_a", odat_a, hold_a);
      end
      if (stall_b) begin
        chk("hold_vld_b", ovld_b, 1);
        chk("hold_dat_b", odat_b, hold_b);
      end
      if (ovld_a && ordy_a) begin
        if (q_a.size() == 0) chk("spurious_a", ovld_a, 0);
        else begin e = q_a.pop_front(); chk("data_a", odat_a, e); end
      end
      if (ovld_b && ordy_b) begin
        if (q_b.size() == 0) chk("spurious_b", ovld_b, 0);
        else begin e = q_b.pop_front(); chk("data_b", odat_b, e); end
      end
      if (ivld_a && irdy_a) begin q_a.push_back(idat_a); acc_a++; end
      if (ivld_b && irdy_b) begin q_b.push_back(idat_b); acc_b++; end
      stall_a = ovld_a && !ordy_a; hold_a = odat_a;
      stall_b = ovld_b && !ordy_b; hold_b = odat_b;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nxt, prev, cyc, r;
    logic ir;
    rst = 1'b1; ivld_a = 1'b1; idat_a = 8'hAA; ordy_a = 1'b1;
    ivld_b = 1'b1; idat_b = 8'hAA; ordy_b = 1'b1;

    // Reset with a valid beat offered: nothing may be captured
    cycle(); cycle();
    rst = 1'b0; ivld_a = 1'b0; ivld_b = 1'b0;
    chk("rst_ovld_a", ovld_a, 0); chk("rst_odat_a", odat_a, 0); chk("rst_irdy_a", irdy_a, 1);
    chk("rst_ovld_b", ovld_b, 0); chk("rst_odat_b", odat_b, 0); chk("rst_irdy_b", irdy_b, 1);
    repeat (4) cycle();
    chk("rst_no_aa_a", ovld_a, 0);

    // Pass-through: 1-cycle latency, back-to-back
    for (int i = 1; i <= 3; i++) begin
      idat_a = 8'(i); ivld_a = 1'b1;
      chk("pt_irdy", irdy_a, 1);
      cycle();
      chk("pt_ovld", ovld_a, 1);
      chk("pt_odat", odat_a, i);
    end
    ivld_a = 1'b0;
    cycle();
    chk("pt_idle", ovld_a, 0);

    // Backpressure: 0x10 accepted, ordy drops, only 0x11 fits in B
    nxt = 0;
    idat_a = 8'h10; ivld_a = 1'b1; ordy_a = 1'b1;
    prev = acc_a; cycle(); if (acc_a != prev) nxt++;
    ordy_a = 1'b0;
    repeat (6) begin
      idat_a = 8'(8'h10 + nxt);
      prev = acc_a; cycle(); if (acc_a != prev) nxt++;
    end
    chk("bp_accepted", nxt, 2);
    chk("bp_irdy", irdy_a, 0);
    chk("bp_odat", odat_a, 8'h10);
    ordy_a = 1'b1;
    idat_a = 8'(8'h10 + nxt);
    prev = acc_a; cycle(); if (acc_a != prev) nxt++;
    chk("bp_recover_irdy", irdy_a, 1);
    chk("bp_recover_odat", odat_a, 8'h11);
    cyc = 0;
    while (nxt < 16 && cyc < 100) begin
      idat_a = 8'(8'h10 + nxt);
      prev = acc_a; cycle(); if (acc_a != prev) nxt++;
      chk("bp_nogap", ovld_a, 1);
      cyc++;
    end
    chk("bp_done", nxt, 16);
    ivld_a = 1'b0;
    repeat (3) cycle();
    chk("bp_drained", q_a.size(), 0);

    // Mid-stream reset with A and B both full
    ordy_a = 1'b0; ivld_a = 1'b1;
    idat_a = 8'h40; cycle();
    idat_a = 8'h41; cycle();
    chk("mr_full_irdy", irdy_a, 0);
    chk("mr_full_ovld", ovld_a, 1);
    rst = 1'b1; cycle(); rst = 1'b0;
    chk("mr_ovld", ovld_a, 0); chk("mr_irdy", irdy_a, 1); chk("mr_odat", odat_a, 0);
    ordy_a = 1'b1;
    idat_a = 8'h50; cycle();
    chk("mr_d50", odat_a, 8'h50);
    idat_a = 8'h51; cycle();
    chk("mr_d51", odat_a, 8'h51);
    ivld_a = 1'b0; cycle();

    // FEED_STAGES=2: latency of 3 cycles
    ordy_b = 1'b1; ivld_b = 1'b1; idat_b = 8'h3C;
    cycle(); ivld_b = 1'b0;
    chk("lat3_c1", ovld_b, 0);
    cycle();
    chk("lat3_c2", ovld_b, 0);
    cycle();
    chk("lat3_c3", ovld_b, 1);
    chk("lat3_dat", odat_b, 8'h3C);
    cycle();
    // Sustained streaming
    for (int i = 0; i < 20; i++) begin
      ivld_b = 1'b1; idat_b = 8'(8'h80 + i);
      chk("s3_irdy", irdy_b, 1);
      cycle();
      if (i >= 2) chk("s3_ovld", ovld_b, 1);
    end
    ivld_b = 1'b0;
    repeat (5) cycle();
    chk("s3_drained", q_b.size(), 0);
    // Backpressure capacity: 2 beats per stage
    ordy_b = 1'b0; ivld_b = 1'b1; prev = acc_b;
    for (int i = 0; i < 12; i++) begin
      idat_b = 8'(8'hC0 + (acc_b - prev));
      cycle();
    end
    chk("cap3_accepted", acc_b - prev, 6);
    chk("cap3_irdy", irdy_b, 0);
    ivld_b = 1'b0; ordy_b = 1'b1;
    repeat (10) cycle();
    chk("cap3_drained", q_b.size(), 0);

    // Random stress on both instances, holding offered beats until they transfer
    cyc = 0;
    ivld_a = 1'b0; ivld_b = 1'b0;
    while ((acc_a < 10000 || acc_b < 10000) && cyc < 60000) begin
      if (!ivld_a || irdy_a) begin ivld_a = 1'($urandom_range(0, 1)); idat_a = 8'($urandom); end
      if (!ivld_b || irdy_b) begin ivld_b = 1'($urandom_range(0, 1)); idat_b = 8'($urandom); end
      ordy_a = 1'($urandom_range(0, 1));
      ordy_b = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 15);
      if (r == 0) begin
        ir = irdy_a;
        ordy_a = ~ordy_a; #1;
        chk("comb_irdy_a", irdy_a, ir);
        ordy_a = ~ordy_a;
        ir = irdy_b;
        ordy_b = ~ordy_b; #1;
        chk("comb_irdy_b", irdy_b, ir);
        ordy_b = ~ordy_b;
      end
      cycle();
      cyc++;
    end
    chk("stress_budget", (acc_a >= 10000) && (acc_b >= 10000), 1);
    ivld_a = 1'b0; ivld_b = 1'b0; ordy_a = 1'b1; ordy_b = 1'b1;
    repeat (10) cycle();
    chk("stress_drain_a", q_a.size(), 0);
    chk("stress_drain_b", q_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/skid.md
Name: skid

Overview:
- Fully registered two-entry skid buffer (register slice) for a valid/ready stream.
- Breaks combinational paths on both the forward path (odat/ovld) and the backward path (irdy), at full throughput.
- Used at block outputs, e.g. after the memory-bank read stage of inner_shuffle, to decouple downstream backpressure timing from internal control.
- An optional chain of extra identical stages adds pipelining.

Parameters:
- DATA_WIDTH, 8, width in bits of the payload idat/odat (≥1).
- FEED_STAGES, 0, number of additional skid stages cascaded after the first; total stages = 1+FEED_STAGES.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset.
- idat  input  DATA_WIDTH  upstream payload.
- ivld  input  1  upstream valid.
- irdy  output  1  ready to upstream.
- odat  output  DATA_WIDTH  downstream payload.
- ovld  output  1  downstream valid.
- ordy  input  1  downstream ready.

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high. These are fixed.
- Transfer rule: a beat transfers on a port when vld && rdy are high at a rising edge.
  - The producer must hold data and valid stable until the beat transfers.
  - The block guarantees this on its output: while ovld=1 and ordy=0, odat and ovld do not change.
- Per-stage state:
  - Main register: A_dat, A_vld. Drives odat/ovld of the stage.
  - Skid register: B_dat, B_vld.
- Stage outputs, all driven directly from flops with no combinational input→output path:
  - irdy = !B_vld, registered.
  - ovld = A_vld.
  - odat = A_dat.
- Reset, applied at a clock edge with rst=1, in every stage:
  - A_vld=0, B_vld=0, A_dat=0, B_dat=0.
  - After that edge, in every stage: ovld=0, odat=0, irdy=1.
  - rst overrides any concurrent handshake. Beats in flight are discarded and are not output after reset.
- Next-state rules per stage, evaluated each edge with rst=0. Define in_xfer = ivld && irdy and out_xfer = A_vld && ordy.
  - A empty or out_xfer, with B_vld=1: A ← B; B_vld ← in_xfer; B_dat ← idat if in_xfer.
  - A empty or out_xfer, with B_vld=0: A_vld ← in_xfer; A_dat ← idat if in_xfer.
  - A full and !ordy: A holds. If in_xfer, then B ← idat and B_vld ← 1.
- Ordering: strict FIFO order, no loss, no duplication.
- Capacity: 2 beats per stage.
- Latency (empty stage): a beat accepted at edge n appears on ovld/odat after edge n, i.e. 1 cycle per stage. Total latency is 1+FEED_STAGES cycles.
- Throughput: with ordy held 1 and ivld held 1, one beat transfers per cycle indefinitely, and irdy stays 1.
- Backpressure: after ordy drops, the stage accepts at most one more beat into B, then irdy=0 from the next cycle on.
- Recovery: when ordy returns high, B drains into A at the first out_xfer. irdy returns to 1 in the cycle after B empties.
- Simultaneous in_xfer and out_xfer with B empty: the new beat replaces A in the same edge. There is no bubble.
- Cascade: stage k's odat/ovld/ordy connect to stage k+1's idat/ivld/irdy.
  - External irdy comes from stage 0.
  - External odat/ovld come from the last stage.
- Data bits of empty registers are don't-care to consumers but must be deterministic: hold the last value, or 0 after reset.

Test Plan:
- Reset: drive rst=1 for 2 cycles with ivld=1 and idat=0xAA -> after release, ovld=0, odat=0, irdy=1, and no 0xAA beat emerges.
- Pass-through, DATA_WIDTH=8, ordy=1: send 0x01, 0x02, 0x03 on consecutive cycles -> same values on consecutive cycles, 1 cycle after acceptance; irdy constantly 1.
- Backpressure: stream 0x10..0x1F with ordy=0 from the second beat on -> ovld=1 holds 0x10 stable; exactly one further beat (0x11) is accepted, then irdy=0. Raise ordy -> output 0x10, 0x11, 0x12... in order, no gaps or duplicates; irdy=1 one cycle after the skid register empties.
- Mid-stream reset: assert rst while both A and B are full -> next cycle ovld=0, irdy=1; the subsequent stream 0x50, 0x51 arrives uncorrupted.
- Random stress: 10,000 beats, ivld and ordy each random at 50% -> scoreboard shows exact order; odat stable whenever ovld && !ordy; irdy never depends combinationally on ordy (toggle ordy mid-cycle, irdy unchanged).
- FEED_STAGES=2: single beat 0x3C into an empty pipe -> ovld rises 3 cycles after acceptance. Sustained streaming at 1 beat/cycle with ordy=1. With ordy=0, total accepted beats before irdy=0 is 6.
